// File: rtl/axis_addr_burst.sv
// -----------------------------------------------------------------------------
// axis_addr_burst
//
// AXI address-channel generator for the AXIS streaming datapath. A command
// (start byte address + length in stream elements) is split into AXI bursts.
// Each burst is limited by BURST_MAX beats, by the 4 KB page it starts in, and
// by the words still to transfer. At most MAX_OUTSTANDING bursts may be issued
// but not yet completed. cmd_done pulses once every issued burst has completed.
//
// Ports
//   clk          : clock, all logic on the rising edge
//   rst          : synchronous active-high reset
//   cfg_address  : start byte address (low log2(BYTES) bits ignored)
//   cfg_length   : transfer length in stream elements
//   cfg_valid    : command valid
//   cfg_ready    : command ready (high only while idle)
//   axi_aready   : AXI address ready
//   axi_avalid   : AXI address valid
//   axi_aaddr    : burst start address
//   axi_alen     : burst length minus one
//   burst_done   : one-cycle pulse per completed burst
//   cmd_done     : one-cycle pulse when the whole command has completed
// -----------------------------------------------------------------------------
module axis_addr_burst #(
    parameter int CONFIG_DWIDTH   = 32,
    parameter int WIDTH_RATIO     = 16,
    parameter int CONVERT_SHIFT   = 4,
    parameter int AXI_LEN_WIDTH   = 8,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 256,
    parameter int BURST_MAX       = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CONFIG_DWIDTH-1:0]  cfg_address,
    input  logic [CONFIG_DWIDTH-1:0]  cfg_length,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic                      axi_aready,
    output logic                      axi_avalid,
    output logic [AXI_ADDR_WIDTH-1:0] axi_aaddr,
    output logic [AXI_LEN_WIDTH-1:0]  axi_alen,
    input  logic                      burst_done,
    output logic                      cmd_done
);

    localparam int BYTES      = AXI_DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);
    // One extra bit so that cfg_length + WIDTH_RATIO - 1 cannot overflow.
    localparam int WORDS_W    = CONFIG_DWIDTH + 1;
    localparam int LEN_W      = AXI_LEN_WIDTH + 1;
    localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [6:0] {
        S_IDLE  = 7'b0000001,
        S_SETUP = 7'b0000010,
        S_CALC  = 7'b0000100,
        S_ISSUE = 7'b0001000,
        S_WAIT  = 7'b0010000,
        S_DRAIN = 7'b0100000,
        S_DONE  = 7'b1000000
    } state_t;

    state_t                    state_r;
    state_t                    state_nxt;

    logic [AXI_ADDR_WIDTH-1:0] addr_r;
    logic [AXI_LEN_WIDTH-1:0]  alen_r;
    logic [WORDS_W-1:0]        words_r;
    logic [LEN_W-1:0]          len_r;
    logic [OUT_W-1:0]          outstanding_r;

    logic [AXI_ADDR_WIDTH-1:0] addr_in;
    logic [WORDS_W-1:0]        words_in;
    logic [12:0]               bytes_to_4k;
    logic [WORDS_W-1:0]        len_calc;
    logic [WORDS_W-1:0]        words_rem;
    logic [AXI_ADDR_WIDTH-1:0] addr_step;
    logic                      out_lt_max;
    logic                      addr_hs;
    logic                      cmd_accept;

    function automatic logic [WORDS_W-1:0] min_w(input logic [WORDS_W-1:0] a,
                                                  input logic [WORDS_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Command decode: byte address aligned to the AXI data word, element
    // count rounded up to whole AXI words.
    assign addr_in  = AXI_ADDR_WIDTH'(cfg_address) & ({AXI_ADDR_WIDTH{1'b1}} << BYTE_SHIFT);
    assign words_in = (WORDS_W'(cfg_length) + WORDS_W'(WIDTH_RATIO - 1)) >> CONVERT_SHIFT;

    // Beats left before the next 4 KB page. addr_r is word aligned, so the
    // division by BYTES is exact.
    assign bytes_to_4k = 13'h1000 - {1'b0, addr_r[11:0]};
    assign len_calc    = min_w(min_w(words_r, WORDS_W'(BURST_MAX)),
                               WORDS_W'(bytes_to_4k >> BYTE_SHIFT));

    assign words_rem  = words_r - WORDS_W'(len_r);
    assign addr_step  = AXI_ADDR_WIDTH'(len_r) << BYTE_SHIFT;
    assign out_lt_max = (outstanding_r < OUT_W'(MAX_OUTSTANDING));
    assign cmd_accept = (state_r == S_IDLE) && cfg_valid;
    assign addr_hs    = (state_r == S_ISSUE) && axi_aready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_r;
        cfg_ready  = 1'b0;
        axi_avalid = 1'b0;
        cmd_done   = 1'b0;
        case (state_r)
            S_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) state_nxt = S_SETUP;
            end
            S_SETUP: begin
                state_nxt = (words_r == '0) ? S_DONE : S_CALC;
            end
            S_CALC: begin
                state_nxt = out_lt_max ? S_ISSUE : S_WAIT;
            end
            S_WAIT: begin
                if (out_lt_max) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                axi_avalid = 1'b1;
                if (axi_aready) state_nxt = (words_rem != '0) ? S_CALC : S_DRAIN;
            end
            S_DRAIN: begin
                if (outstanding_r == '0) state_nxt = S_DONE;
            end
            S_DONE: begin
                cmd_done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Address and beat count are visible on the AXI port, so they are reset.
    // The address wraps modulo 2^AXI_ADDR_WIDTH by plain truncation.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r <= '0;
            alen_r <= '0;
        end else begin
            if (cmd_accept) begin
                addr_r <= addr_in;
            end else if (addr_hs) begin
                addr_r <= addr_r + addr_step;
            end
            if (state_r == S_CALC) begin
                alen_r <= AXI_LEN_WIDTH'(len_calc - WORDS_W'(1));
            end
        end
    end

    // Internal working registers: always loaded before use.
    always_ff @(posedge clk) begin
        if (cmd_accept) begin
            words_r <= words_in;
        end else if (addr_hs) begin
            words_r <= words_rem;
        end
        if (state_r == S_CALC) begin
            len_r <= LEN_W'(len_calc);
        end
    end

    // Outstanding bursts. Completions are counted in every state so that
    // stragglers from an earlier command still drain the counter; a
    // completion with nothing outstanding is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_r <= '0;
        end else if (addr_hs && !burst_done) begin
            outstanding_r <= outstanding_r + OUT_W'(1);
        end else if (!addr_hs && burst_done && (outstanding_r != '0)) begin
            outstanding_r <= outstanding_r - OUT_W'(1);
        end
    end

    assign axi_aaddr = addr_r;
    assign axi_alen  = alen_r;

endmodule

// File: doc/axis_addr_burst.md
# axis_addr_burst

Parametrised AXI write/read address-channel generator for the AXIS streaming datapath. Accepts a transfer command (start byte address, length in stream elements) and splits it into AXI bursts. Each burst is bounded by a configurable maximum length, by the AXI 4 KB boundary and by the words remaining. The number of outstanding bursts is throttled using a completion input, and the block pulses `cmd_done` once every issued burst has completed.

## Interface
- `CONFIG_DWIDTH`, 32, width of command fields.
- `WIDTH_RATIO`, 16, stream elements per AXI data word (power of two).
- `CONVERT_SHIFT`, 4, log2(`WIDTH_RATIO`).
- `AXI_LEN_WIDTH`, 8, width of `axi_alen`.
- `AXI_ADDR_WIDTH`, 32, AXI address width.
- `AXI_DATA_WIDTH`, 256, AXI data width in bits; BYTES = `AXI_DATA_WIDTH`/8.
- `BURST_MAX`, 64, maximum beats per burst; power of two, 1 to 2^`AXI_LEN_WIDTH`.
- `MAX_OUTSTANDING`, 4, maximum issued-but-uncompleted bursts (≥1).
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `cfg_address` in `CONFIG_DWIDTH`: start byte address. Low log2(BYTES) bits are ignored (forced to 0).
- `cfg_length` in `CONFIG_DWIDTH`: transfer length in stream elements.
- `cfg_valid` in 1 / `cfg_ready` out 1: command handshake.
- `axi_aready` in 1 / `axi_avalid` out 1: AXI address handshake.
- `axi_aaddr` out `AXI_ADDR_WIDTH`: burst start address.
- `axi_alen` out `AXI_LEN_WIDTH`: beats-1 of the current burst.
- `burst_done` in 1: one-cycle pulse per completed burst (write response or last read beat).
- `cmd_done` out 1: one-cycle pulse when the command has fully completed.

## Operation
- Reset values:
  - `cfg_ready`=1.
  - `axi_avalid`=0, `axi_aaddr`=0, `axi_alen`=0.
  - `cmd_done`=0.
  - Outstanding counter 0; state IDLE.
- One-hot states: IDLE, SETUP, CALC, ISSUE, WAIT, DRAIN, DONE.
- IDLE: `cfg_ready`=1 in this state only.
  - On `cfg_valid`, register the aligned address and `words` = (`cfg_length`+`WIDTH_RATIO`-1)>>`CONVERT_SHIFT`, computed at `CONFIG_DWIDTH`+1 bits so no overflow.
  - Go to SETUP.
- SETUP: if `words`==0 go to DONE; else go to CALC.
- CALC: register `len` = min(`words`, `BURST_MAX`, (4096-addr[11:0])/BYTES). Go to ISSUE if outstanding < `MAX_OUTSTANDING`, else WAIT.
- WAIT: go to ISSUE in the first cycle in which outstanding < `MAX_OUTSTANDING`.
- ISSUE: `axi_avalid`=1 and `axi_alen`=`len`-1; `axi_aaddr` is held stable until the handshake.
  - On `axi_aready`: addr += `len`*BYTES (modulo 2^`AXI_ADDR_WIDTH`), `words` -= `len`, outstanding +1.
  - Then go to CALC if `words` (after update) ≠0, else DRAIN.
- DRAIN: go to DONE when outstanding==0.
- DONE: `cmd_done`=1 for one cycle, then IDLE.
- Outstanding counter, width clog2(`MAX_OUTSTANDING`+1):
  - +1 on address handshake; -1 on `burst_done`; unchanged when both occur in the same cycle.
  - `burst_done` with counter 0 and no handshake is ignored; the counter saturates at 0.
- `burst_done` is counted in every state, including IDLE. Completions from a prior command drain the counter.
- A 4 KB boundary is never crossed by any burst.

## Timing
- Command accepted at edge 0: SETUP during cycle 1, CALC during cycle 2, first `axi_avalid` in cycle 3.
- After each handshake, one CALC cycle precedes the next `axi_avalid`. Sustained rate is one burst per 2 cycles when `axi_aready`=1.
- `axi_avalid`, once high, stays high with `axi_aaddr`/`axi_alen` unchanged until `axi_aready`.
- Zero length: SETUP→DONE, so `cmd_done` is high in cycle 2. No `axi_avalid` is issued.
- The last handshake and the final `burst_done` may coincide. `cmd_done` then rises one cycle after DRAIN sees outstanding==0.
- `rst` mid-command: the next cycle returns to IDLE with all reset values. The command is discarded and no `cmd_done` is issued.
- `cfg_valid` outside IDLE is ignored.

## Test plan
- Defaults, addr 0x0, length 3200 → words 200: four bursts, (alen, aaddr) = (63, 0x0), (63, 0x800), (63, 0x1000), (7, 0x1800); then `cmd_done`.
- 4 KB split, addr 0x0FC0, length 1600 (100 words): bursts (1, 0xFC0), (63, 0x1000), (33, 0x1800); no burst crosses 0x1000 or 0x2000.
- Rounding and alignment:
  - Length 17 → words 2, alen 1.
  - addr 0x1F (low 5 bits dropped) → aaddr 0x0.
  - Length 0 → no `axi_avalid`, `cmd_done` in cycle 2.
- Throttle, `MAX_OUTSTANDING`=2, 5-burst command, `burst_done` held low:
  - Exactly 2 handshakes, then the block stays in WAIT with `axi_avalid`=0.
  - Each `burst_done` pulse releases one burst.
  - `cmd_done` only after the 5th completion.
- Backpressure: `axi_aready` low for 10 cycles while `axi_avalid`=1 → `axi_aaddr` and `axi_alen` stable; the simultaneous handshake+`burst_done` leaves the counter unchanged.
- `rst` asserted during the 2nd burst's ISSUE → `axi_avalid` and `cmd_done` are 0 and `cfg_ready`=1 the next cycle. A new command then runs correctly from its own address.
